axi_addr: RTL and testbench

AXI slave burst address generator. It takes the address of the current beat and the burst attributes (AxSIZE, AxBURST, AxLEN), and produces the address of the next beat. It supports FIXED, INCR and WRAP bursts. It sits in the AXI slave read and write address paths, feeding the memory/register access address each beat. The output is registered.

---
 rtl/axi_addr.sv | 117 +++++++++++
 tb/tb_axi_addr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/axi_addr.sv
// AXI slave burst address generator.
// Computes the address of the next beat from the current beat address and
// the burst attributes (size, type, length) for FIXED, INCR and WRAP bursts.
// The result is registered: one cycle of latency, a new result every cycle.
//
// Optional build macro: AXI_ADDR_INCR_OUT_EN
//   When defined, the registered byte increment (1 << i_size) is also
//   presented on o_incr. When undefined, o_incr and its register are absent.

module axi_addr #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] i_last_addr,
    input  logic [2:0]    i_size,
    input  logic [1:0]    i_burst,
    input  logic [7:0]    i_len,
    output logic [AW-1:0] o_next_addr
`ifdef AXI_ADDR_INCR_OUT_EN
    ,
    output logic [7:0]    o_incr
`endif
);

    // Internal arithmetic width. It must hold the largest wrap span
    // (128 bytes * 16 beats = 2048) plus a carry bit above both that span and
    // the address itself, so that masking happens before truncation to AW.
    localparam int XW = ((AW > 12) ? AW : 12) + 1;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    logic [7:0]    incr;
    logic [XW-1:0] lastX;
    logic [XW-1:0] lowMask;
    logic [XW-1:0] alignedX;
    logic [XW-1:0] sumX;
    logic [XW-1:0] wrapBytes;
    logic [XW-1:0] wrapMask;
    logic [2:0]    wrapShift;
    logic          wrapLegal;
    logic [AW-1:0] next_addr_d;
    logic [AW-1:0] next_addr_q;

    // Next-beat address: align, step by one beat, then apply the burst rule.
    always_comb begin
        incr      = 8'd1 << i_size;
        lastX     = XW'(i_last_addr);
        lowMask   = (XW'(1) << i_size) - XW'(1);
        alignedX  = lastX & ~lowMask;
        sumX      = alignedX + XW'(incr);

        wrapShift = 3'd0;
        wrapLegal = 1'b1;
        case (i_len)
            8'd1:    wrapShift = 3'd1;
            8'd3:    wrapShift = 3'd2;
            8'd7:    wrapShift = 3'd3;
            8'd15:   wrapShift = 3'd4;
            default: wrapLegal = 1'b0;
        endcase

        wrapBytes = XW'(incr) << wrapShift;
        if (wrapBytes >= (XW'(1) << AW)) begin
            wrapMask = '1;
        end else begin
            wrapMask = wrapBytes - XW'(1);
        end

        next_addr_d = i_last_addr;
        case (burst_e'(i_burst))
            BURST_FIXED: next_addr_d = i_last_addr;
            BURST_INCR:  next_addr_d = AW'(sumX);
            BURST_WRAP: begin
                if (wrapLegal) begin
                    next_addr_d = AW'((lastX & ~wrapMask) | (sumX & wrapMask));
                end else begin
                    next_addr_d = AW'(sumX);
                end
            end
            BURST_RSVD:  next_addr_d = i_last_addr;
            default:     next_addr_d = i_last_addr;
        endcase
    end

    // Output register for the next-beat address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            next_addr_q <= '0;
        end else begin
            next_addr_q <= next_addr_d;
        end
    end

    assign o_next_addr = next_addr_q;

`ifdef AXI_ADDR_INCR_OUT_EN
    logic [7:0] incr_q;

    // Output register for the per-beat byte increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            incr_q <= '0;
        end else begin
            incr_q <= incr;
        end
    end

    assign o_incr = incr_q;
`endif

endmodule

// File: tb/tb_axi_addr.sv
// Self-checking bench for axi_addr (AW = 12): a table of directed vectors
// applied back to back, plus hand-written sequences for reset behaviour and
// a multi-beat wrapping burst.

module tb_axi_addr;

    localparam int AW = 12;

    logic          clk;
    logic          rstn;
    logic [AW-1:0] i_last_addr;
    logic [2:0]    i_size;
    logic [1:0]    i_burst;
    logic [7:0]    i_len;
    logic [AW-1:0] o_next_addr;
`ifdef AXI_ADDR_INCR_OUT_EN
    logic [7:0]    o_incr;
`endif

    int total;
    int bad;

    typedef struct {
        string         name;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [7:0]    len;
        logic [AW-1:0] expAddr;
        logic [7:0]    expIncr;
    } vec_t;

    vec_t vecs[$];

    axi_addr #(.AW(AW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_last_addr (i_last_addr),
        .i_size      (i_size),
        .i_burst     (i_burst),
        .i_len       (i_len),
        .o_next_addr (o_next_addr)
`ifdef AXI_ADDR_INCR_OUT_EN
        ,
        .o_incr      (o_incr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive inputs on the falling edge, so the next rising edge samples them.
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [2:0] size,
                                 input logic [1:0] burst, input logic [7:0] len);
        @(negedge clk);
        i_last_addr = addr;
        i_size      = size;
        i_burst     = burst;
        i_len       = len;
    endtask

    task automatic addVec(input string name, input logic [AW-1:0] addr,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [7:0] len, input logic [AW-1:0] expAddr,
                          input logic [7:0] expIncr);
        vec_t v;
        v.name    = name;
        v.addr    = addr;
        v.size    = size;
        v.burst   = burst;
        v.len     = len;
        v.expAddr = expAddr;
        v.expIncr = expIncr;
        vecs.push_back(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        addVec("wrap8x8_078",   12'h078, 3'd3, 2'b10, 8'd7,  12'h040, 8'd8);
        addVec("wrap8x8_07C",   12'h07C, 3'd3, 2'b10, 8'd7,  12'h040, 8'd8);
        addVec("wrap8x8_080",   12'h080, 3'd3, 2'b10, 8'd7,  12'h088, 8'd8);
        addVec("wrap4x4_03C",   12'h03C, 3'd2, 2'b10, 8'd3,  12'h030, 8'd4);
        addVec("wrap4x4_034",   12'h034, 3'd2, 2'b10, 8'd3,  12'h038, 8'd4);
        addVec("incr4_FFC",     12'hFFC, 3'd2, 2'b01, 8'd0,  12'h000, 8'd4);
        addVec("incr1_005",     12'h005, 3'd0, 2'b01, 8'd0,  12'h006, 8'd1);
        addVec("incr4_013",     12'h013, 3'd2, 2'b01, 8'd0,  12'h014, 8'd4);
        addVec("fixed_123",     12'h123, 3'd2, 2'b00, 8'd3,  12'h123, 8'd4);
        addVec("rsvd_0A5",      12'h0A5, 3'd1, 2'b11, 8'd7,  12'h0A5, 8'd2);
        addVec("wrapbad_01C",   12'h01C, 3'd2, 2'b10, 8'd5,  12'h020, 8'd4);
        addVec("wrap1x16_00F",  12'h00F, 3'd0, 2'b10, 8'd15, 12'h000, 8'd1);
        addVec("wrap128x16_F80",12'hF80, 3'd7, 2'b10, 8'd15, 12'h800, 8'd128);
        addVec("incr128_F85",   12'hF85, 3'd7, 2'b01, 8'd0,  12'h000, 8'd128);
        addVec("wrap2x2_0A3",   12'h0A3, 3'd1, 2'b10, 8'd1,  12'h0A0, 8'd2);
        addVec("fixed_FFF",     12'hFFF, 3'd5, 2'b00, 8'd0,  12'hFFF, 8'd32);
        addVec("incr2_7FF",     12'h7FF, 3'd1, 2'b01, 8'd0,  12'h800, 8'd2);
        addVec("incr16_3F7",    12'h3F7, 3'd4, 2'b01, 8'd0,  12'h400, 8'd16);
        addVec("incr32_2A0",    12'h2A0, 3'd5, 2'b01, 8'd0,  12'h2C0, 8'd32);
        addVec("incr64_555",    12'h555, 3'd6, 2'b01, 8'd0,  12'h580, 8'd64);

        // Reset held with arbitrary inputs applied.
        rstn        = 1'b0;
        i_last_addr = 12'h5A5;
        i_size      = 3'd2;
        i_burst     = 2'b01;
        i_len       = 8'd3;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_addr", 32'(o_next_addr), 32'h0);
`ifdef AXI_ADDR_INCR_OUT_EN
        checkOutput("reset_incr", 32'(o_incr), 32'h0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors, one per cycle.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].size, vecs[i].burst, vecs[i].len);
            @(posedge clk);
            #1;
            checkOutput(vecs[i].name, 32'(o_next_addr), 32'(vecs[i].expAddr));
`ifdef AXI_ADDR_INCR_OUT_EN
            checkOutput({vecs[i].name, "_incr"}, 32'(o_incr), 32'(vecs[i].expIncr));
`endif
        end

        // Multi-beat WRAP burst (8 beats of 8 bytes) fed from its own output.
        begin
            logic [AW-1:0] walkExp[6];
            walkExp = '{12'h060, 12'h068, 12'h070, 12'h078, 12'h040, 12'h048};
            applyStimulus(12'h05B, 3'd3, 2'b10, 8'd7);
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                checkOutput($sformatf("wrap_walk_%0d", k), 32'(o_next_addr), 32'(walkExp[k]));
                @(negedge clk);
                i_last_addr = o_next_addr;
            end
        end

`ifdef AXI_ADDR_INCR_OUT_EN
        // Size sweep on the increment output.
        for (int s = 0; s < 8; s++) begin
            logic [7:0] expInc;
            expInc = 8'd1 << s;
            applyStimulus(12'h100, 3'(s), 2'(s % 4), 8'd3);
            @(posedge clk);
            #1;
            checkOutput($sformatf("incr_sweep_%0d", s), 32'(o_incr), 32'(expInc));
        end
`endif

        // Asynchronous reset mid-stream, then recovery on the first edge.
        applyStimulus(12'h123, 3'd0, 2'b00, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("pre_async_reset", 32'(o_next_addr), 32'h123);
        @(negedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("async_reset_addr", 32'(o_next_addr), 32'h0);
`ifdef AXI_ADDR_INCR_OUT_EN
        checkOutput("async_reset_incr", 32'(o_incr), 32'h0);
`endif
        @(posedge clk);
        #1;
        checkOutput("reset_held_addr", 32'(o_next_addr), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_addr", 32'(o_next_addr), 32'h123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
